// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: divides clk into one-second ticks, keeps minutes:seconds,
// and runs the LIVE/HOLD lap sequencer that selects what the display shows.
module stopwatch_timebase #(
   parameter int CLK_DIV = 100,
   parameter int MAX_MIN = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       count_en,
   input  logic       clear,
   input  logic       lap_req,
   output logic [5:0] live_sec,
   output logic [6:0] live_min,
   output logic [5:0] disp_sec,
   output logic [6:0] disp_min,
   output logic       sec_tick,
   output logic       lap_active,
   output logic       overflow
);

   localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [6:0]       MIN_LAST = 7'(MAX_MIN);
   localparam logic [5:0]       SEC_LAST = 6'd59;

   typedef enum logic {
      LIVE = 1'b0,
      HOLD = 1'b1
   } lap_state_t;

   logic [PRE_W-1:0] pre;
   logic [5:0]       sec;
   logic [6:0]       min;
   logic [5:0]       lap_sec;
   logic [6:0]       lap_min;
   logic             lap_q;
   lap_state_t       state;

   logic             pre_last;
   logic             tick;
   logic             lap_edge;

   assign pre_last = (pre == PRE_LAST);
   assign tick     = count_en & pre_last;
   assign lap_edge = lap_req & ~lap_q;

   // The edge detector keeps tracking the button during clear, so a press that
   // coincides with clear is consumed rather than replayed afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q <= 1'b0;
      end else begin
         lap_q <= lap_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         pre      <= '0;
         sec      <= '0;
         min      <= '0;
         lap_sec  <= '0;
         lap_min  <= '0;
         overflow <= 1'b0;
         sec_tick <= 1'b0;
         state    <= LIVE;
      end else begin
         sec_tick <= tick;

         // A paused prescaler keeps its value so the fractional second survives.
         if (count_en) begin
            if (pre_last) begin
               pre <= '0;
            end else begin
               pre <= pre + PRE_ONE;
            end
         end

         if (tick) begin
            if (sec == SEC_LAST) begin
               sec <= '0;
               if (min == MIN_LAST) begin
                  min      <= '0;
                  overflow <= 1'b1;
               end else begin
                  min <= min + 7'd1;
               end
            end else begin
               sec <= sec + 6'd1;
            end
         end

         // Capture uses the pre-increment registers even when a tick lands on this edge.
         if (lap_edge) begin
            if (state == LIVE) begin
               lap_sec <= sec;
               lap_min <= min;
               state   <= HOLD;
            end else begin
               state <= LIVE;
            end
         end
      end
   end

   assign live_sec   = sec;
   assign live_min   = min;
   assign lap_active = (state == HOLD);
   assign disp_sec   = lap_active ? lap_sec : sec;
   assign disp_min   = lap_active ? lap_min : min;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase (CLK_DIV=4, MAX_MIN=2) against an
// elapsed-cycle reference model.
module tb_stopwatch_timebase;

   localparam int CLK_DIV = 4;
   localparam int MAX_MIN = 2;

   // clock / reset block
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       count_en = 1'b0;
   logic       clear = 1'b0;
   logic       lap_req = 1'b0;
   logic [5:0] live_sec;
   logic [6:0] live_min;
   logic [5:0] disp_sec;
   logic [6:0] disp_min;
   logic       sec_tick;
   logic       lap_active;
   logic       overflow;

   always #5 clk = ~clk;

   stopwatch_timebase #(.CLK_DIV(CLK_DIV), .MAX_MIN(MAX_MIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_en   (count_en),
      .clear      (clear),
      .lap_req    (lap_req),
      .live_sec   (live_sec),
      .live_min   (live_min),
      .disp_sec   (disp_sec),
      .disp_min   (disp_min),
      .sec_tick   (sec_tick),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: elapsed enabled cycles since reset/clear, lap snapshot in seconds.
   int m_en_cnt    = 0;
   int m_lap_total = 0;
   bit m_hold      = 1'b0;
   bit m_tick      = 1'b0;
   bit m_lap_q     = 1'b0;

   function automatic int m_total();
      return m_en_cnt / CLK_DIV;
   endfunction

   function automatic logic [28:0] exp_all();
      int  lt;
      int  dt;
      logic [5:0] ls;
      logic [6:0] lm;
      logic [5:0] ds;
      logic [6:0] dm;
      lt = m_total();
      dt = m_hold ? m_lap_total : lt;
      ls = 6'(lt % 60);
      lm = 7'((lt / 60) % (MAX_MIN + 1));
      ds = 6'(dt % 60);
      dm = 7'((dt / 60) % (MAX_MIN + 1));
      return {ls, lm, ds, dm, m_tick, m_hold, (lt >= 60 * (MAX_MIN + 1))};
   endfunction

   function automatic logic [28:0] act_all();
      return {live_sec, live_min, disp_sec, disp_min, sec_tick, lap_active, overflow};
   endfunction

   // driver: apply inputs for one cycle, advance model, sample 1 time unit after the edge
   task automatic drive_cycle(input bit r, input bit ce, input bit clr, input bit lap);
      bit edge_seen;
      rst      = r;
      count_en = ce;
      clear    = clr;
      lap_req  = lap;
      if (r) begin
         m_en_cnt = 0; m_lap_total = 0; m_hold = 0; m_tick = 0; m_lap_q = 0;
      end else begin
         edge_seen = lap & ~m_lap_q;
         m_lap_q   = lap;
         if (clr) begin
            m_en_cnt = 0; m_lap_total = 0; m_hold = 0; m_tick = 0;
         end else begin
            if (edge_seen) begin
               if (!m_hold) begin
                  m_lap_total = m_total();
                  m_hold      = 1'b1;
               end else begin
                  m_hold = 1'b0;
               end
            end
            if (ce) m_en_cnt++;
            m_tick = ce && (m_en_cnt % CLK_DIV == 0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_enabled(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, 1, 0, 0);
   endtask

   task automatic test_reset();
      drive_cycle(1, 1, 0, 0);
      drive_cycle(1, 0, 0, 0);
      checks++;
      if (act_all() !== 29'd0) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", act_all(), 29'd0);
      end
   endtask

   task automatic test_count();
      for (int i = 1; i <= 12; i++) begin
         drive_cycle(0, 1, 0, 0);
         checks++;
         if (sec_tick !== (i % 4 == 0)) begin
            errors++;
            $display("FAIL count_tick cycle %0d: got %b want %b", i, sec_tick, (i % 4 == 0));
         end
         checks++;
         if (act_all() !== exp_all()) begin
            errors++;
            $display("FAIL count_state cycle %0d: got %h want %h", i, act_all(), exp_all());
         end
      end
      checks++;
      if (live_sec !== 6'd3 || live_min !== 7'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL count_final: got %0d:%0d ovf %b want 0:3 ovf 0", live_min, live_sec, overflow);
      end
   endtask

   task automatic test_pause();
      drive_cycle(0, 0, 1, 0);
      run_enabled(2);
      for (int i = 0; i < 10; i++) begin
         drive_cycle(0, 0, 0, 0);
         checks++;
         if (sec_tick !== 1'b0 || live_sec !== 6'd0) begin
            errors++;
            $display("FAIL pause_no_tick %0d: got tick %b sec %0d want tick 0 sec 0", i, sec_tick, live_sec);
         end
      end
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (sec_tick !== 1'b0) begin
         errors++;
         $display("FAIL pause_early_tick: got %b want 0", sec_tick);
      end
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (sec_tick !== 1'b1 || live_sec !== 6'd1) begin
         errors++;
         $display("FAIL pause_resume_tick: got tick %b sec %0d want tick 1 sec 1", sec_tick, live_sec);
      end
   endtask

   task automatic test_rollover();
      drive_cycle(0, 0, 1, 0);
      run_enabled(59 * 4);
      checks++;
      if (live_min !== 7'd0 || live_sec !== 6'd59) begin
         errors++;
         $display("FAIL roll_at_059: got %0d:%0d want 0:59", live_min, live_sec);
      end
      run_enabled(4);
      checks++;
      if (live_min !== 7'd1 || live_sec !== 6'd0 || sec_tick !== 1'b1) begin
         errors++;
         $display("FAIL roll_to_100: got %0d:%0d tick %b want 1:0 tick 1", live_min, live_sec, sec_tick);
      end
      run_enabled((179 - 60) * 4);
      checks++;
      if (live_min !== 7'd2 || live_sec !== 6'd59 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL roll_at_259: got %0d:%0d ovf %b want 2:59 ovf 0", live_min, live_sec, overflow);
      end
      run_enabled(4);
      checks++;
      if (live_min !== 7'd0 || live_sec !== 6'd0 || overflow !== 1'b1 || sec_tick !== 1'b1) begin
         errors++;
         $display("FAIL roll_wrap: got %0d:%0d ovf %b tick %b want 0:0 ovf 1 tick 1",
                  live_min, live_sec, overflow, sec_tick);
      end
      run_enabled(8);
      checks++;
      if (overflow !== 1'b1 || live_sec !== 6'd2) begin
         errors++;
         $display("FAIL roll_ovf_sticky: got ovf %b sec %0d want ovf 1 sec 2", overflow, live_sec);
      end
   endtask

   task automatic test_lap_hold();
      int transitions;
      logic prev;
      drive_cycle(0, 0, 1, 0);
      run_enabled(20);
      drive_cycle(0, 1, 0, 1);
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (lap_active !== 1'b1 || disp_min !== 7'd0 || disp_sec !== 6'd5) begin
         errors++;
         $display("FAIL lap_capture: got act %b disp %0d:%0d want act 1 disp 0:5", lap_active, disp_min, disp_sec);
      end
      run_enabled(10);
      checks++;
      if (live_sec !== 6'd8 || disp_sec !== 6'd5 || act_all() !== exp_all()) begin
         errors++;
         $display("FAIL lap_frozen: got live %0d disp %0d all %h want live 8 disp 5 all %h",
                  live_sec, disp_sec, act_all(), exp_all());
      end
      drive_cycle(0, 1, 0, 1);
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (lap_active !== 1'b0 || disp_sec !== 6'd8 || disp_min !== 7'd0) begin
         errors++;
         $display("FAIL lap_release: got act %b disp %0d:%0d want act 0 disp 0:8", lap_active, disp_min, disp_sec);
      end
      transitions = 0;
      prev = lap_active;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(0, 1, 0, 1);
         if (lap_active !== prev) transitions++;
         prev = lap_active;
      end
      checks++;
      if (transitions !== 1) begin
         errors++;
         $display("FAIL lap_held_level: got %0d transitions want 1", transitions);
      end
   endtask

   task automatic test_lap_tick_edge();
      drive_cycle(0, 0, 1, 0);
      run_enabled(31);
      drive_cycle(0, 1, 0, 1);
      checks++;
      if (disp_sec !== 6'd7 || live_sec !== 6'd8 || lap_active !== 1'b1 || sec_tick !== 1'b1) begin
         errors++;
         $display("FAIL lap_on_tick: got disp %0d live %0d act %b tick %b want disp 7 live 8 act 1 tick 1",
                  disp_sec, live_sec, lap_active, sec_tick);
      end
      drive_cycle(0, 1, 0, 0);
   endtask

   task automatic test_clear_priority();
      drive_cycle(0, 0, 1, 0);
      run_enabled(181 * 4);
      drive_cycle(0, 1, 0, 1);
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (lap_active !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL clr_setup: got act %b ovf %b want act 1 ovf 1", lap_active, overflow);
      end
      drive_cycle(0, 1, 1, 1);
      checks++;
      if (act_all() !== 29'd0) begin
         errors++;
         $display("FAIL clr_priority: got %h want %h", act_all(), 29'd0);
      end
      drive_cycle(0, 1, 0, 0);
      drive_cycle(0, 1, 0, 0);
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (sec_tick !== 1'b0 || lap_active !== 1'b0) begin
         errors++;
         $display("FAIL clr_no_early_tick: got tick %b act %b want tick 0 act 0", sec_tick, lap_active);
      end
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (sec_tick !== 1'b1 || live_sec !== 6'd1) begin
         errors++;
         $display("FAIL clr_first_tick: got tick %b sec %0d want tick 1 sec 1", sec_tick, live_sec);
      end
   endtask

   task automatic test_reset_lap();
      drive_cycle(1, 0, 0, 1);
      drive_cycle(1, 0, 0, 1);
      drive_cycle(0, 0, 0, 1);
      checks++;
      if (lap_active !== 1'b1 || disp_sec !== 6'd0) begin
         errors++;
         $display("FAIL reset_lap_edge: got act %b disp %0d want act 1 disp 0", lap_active, disp_sec);
      end
   endtask

   task automatic test_random();
      bit lap = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) lap = ~lap;
         drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 149) == 0, lap);
         checks++;
         if (act_all() !== exp_all()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h want %h", i, act_all(), exp_all());
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_pause();
      test_rollover();
      test_lap_hold();
      test_lap_tick_edge();
      test_clear_priority();
      test_reset_lap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_timebase.md
# stopwatch_timebase

Timekeeping datapath and display sequencer for the stopwatch. Consumes the controller's `count_en` / `clear_counters` outputs and divides the system clock into one-second ticks. Maintains the minutes:seconds count and runs a lap-hold state machine that chooses whether the display shows live time or a frozen lap snapshot. Sits between the control FSM and the seven-segment/display driver.

## Interface

**Parameters**
- `CLK_DIV`, default 100: clock cycles per second tick. Must be ≥ 2.
- `MAX_MIN`, default 99: highest minute value before wrap.

**Ports**
- `clk`, input, 1: system clock. Single clock domain; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `count_en`, input, 1: advance time while high. Driven from the control FSM.
- `clear`, input, 1: synchronous clear of time, lap and overflow. Driven from `clear_counters`.
- `lap_req`, input, 1: lap button level, already debounced. The block edge-detects it.
- `live_sec`, output, 6: running seconds, 0..59.
- `live_min`, output, 7: running minutes, 0..MAX_MIN.
- `disp_sec`, output, 6: seconds to display (live or lap).
- `disp_min`, output, 7: minutes to display (live or lap).
- `sec_tick`, output, 1: one-cycle pulse, coincident with each seconds update.
- `lap_active`, output, 1: high while in HOLD.
- `overflow`, output, 1: sticky; set when time wraps from MAX_MIN:59 to 00:00.

## Operation

**Prescaler**
- `pre` counts 0..CLK_DIV-1, width `$clog2(CLK_DIV)`.
- Increments only when `count_en=1`.
- Holds its value when `count_en=0`, so a pause keeps the fractional second.
- When `pre==CLK_DIV-1` and `count_en=1`: `pre` goes to 0 and a time increment occurs on the same edge.

**Time increment**
- `sec+1`.
- At `sec==59`: `sec` goes to 0 and `min+1`.
- At `min==MAX_MIN` and `sec==59`: both go to 0 and `overflow` goes to 1. Counting continues.

**`sec_tick`**
- Registered.
- High for exactly the cycle in which the new time value is first visible.

**Lap FSM, states LIVE and HOLD**
- `lap_edge = lap_req & ~lap_q`. `lap_q` is a register of `lap_req`, updated every cycle including while `clear` is high.
- LIVE: `disp_*` = `live_*`.
  - On `lap_edge`: `lap_sec`/`lap_min` capture the current `live_*` register values (pre-increment, if a tick lands on the same edge). Go to HOLD.
- HOLD: `disp_*` = `lap_*`. Live counting continues underneath.
  - On `lap_edge`: go to LIVE.
- A lap edge is honoured regardless of `count_en`.
- `lap_active = (state==HOLD)`.

**Priority**
- `rst` > `clear` > (tick, lap_edge).
- A `lap_edge` coincident with `clear` is discarded.

**`clear`**
- Sets `pre`, `sec`, `min`, `lap_*`, `overflow` and `sec_tick` to 0, and the state to LIVE, on the next edge.
- Applies even if `count_en=1` in the same cycle.

## Timing

**Reset values** (on the first edge with `rst=1`)
- `pre` = 0.
- All outputs = 0: `live_*`, `disp_*`, `sec_tick`, `lap_active`, `overflow`.
- State = LIVE.
- `lap_q` = 0. As a result, `lap_req` held high through reset yields one `lap_edge` on the first cycle after `rst` falls.

**Tick latency**
- After reset or clear, the first `sec` increment and `sec_tick` appear after the CLK_DIV-th rising edge with `count_en=1` has been sampled.
- Subsequent ticks come every CLK_DIV enabled cycles.
- Disabled cycles stretch the interval 1:1.

**Lap latency**
- `lap_req` rises in cycle N.
- Capture and state change happen at the end of cycle N.
- `disp_*` and `lap_active` reflect the change in cycle N+1.

**Output timing**
- All outputs are registered or a pure mux of registers. No combinational path from inputs to outputs.

**Wrap**
- From 59 s: the seconds rollover and minutes increment occur on the same edge.
- At MAX_MIN:59 → 00:00: `overflow` rises on that same edge and remains set until `clear` or `rst`.

## Test plan

All scenarios use CLK_DIV=4 and MAX_MIN=2.

1. **Reset then count**
   - Stimulus: `rst` for 2 cycles, then `count_en=1` for 12 cycles.
   - Required: `sec_tick` pulses in cycles 4, 8 and 12 after enable. `live_sec` reads 1, 2, 3. `min=0`. `overflow=0`.
2. **Pause keeps the fraction**
   - Stimulus: enable for 2 cycles, disable for 10, enable again.
   - Required: the first tick comes exactly 2 enabled cycles after re-enable. No tick occurs during the pause.
3. **Rollover and overflow**
   - Stimulus: count to 0:59, then one more second; continue to 2:59, then one more second.
   - Required: 0:59 → 1:00 with `sec_tick` high. 2:59 → 0:00 with `overflow=1`, and `overflow` stays high while counting continues.
4. **Lap hold**
   - Stimulus: at live 0:05, pulse `lap_req`; wait 3 s; pulse again.
   - Required: `lap_active=1`; `disp` = 0:05 while `live` reaches 0:08. After the second pulse, `disp` = 0:08 and `lap_active=0`.
   - Also: `lap_req` held high for 20 cycles produces a single transition.
5. **Lap on a tick edge**
   - Stimulus: `lap_req` rises in the cycle where `pre==3` and live = 0:07.
   - Required: lap captures 0:07 while live becomes 0:08 on the same edge.
6. **Clear priority**
   - Stimulus: in HOLD with `overflow=1`, assert `clear`, `count_en` and a `lap_req` edge together.
   - Required next cycle: all time = 0:00, `overflow=0`, `lap_active=0`, `sec_tick=0`. The lap edge is ignored.
   - Then: the first tick comes 4 enabled cycles later.
